// File: rtl/vdu_console_pkg.sv
// Shared types and constants for the VDU teletype console.
// Holds the FSM encodings, control codes and word-index width helper.
package vdu_console_pkg;

    typedef enum logic [2:0] {
        StClear,
        StIdle,
        StPut,
        StScrRd,
        StScrWr,
        StScrFill
    } state_e;

    typedef enum logic [1:0] {
        BusIdle,
        BusAddr,
        BusLow,
        BusHigh
    } bus_state_e;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] BS = 8'h08;
    localparam logic [7:0] FF = 8'h0C;

    function automatic int unsigned idx_width(input int unsigned words);
        return (words < 2) ? 1 : $clog2(words);
    endfunction

endpackage

// File: rtl/vdu_console_if.sv
// Wishbone-style word port between the console initiator and the text VDU.
// Signal names follow the initiator's point of view.
interface vdu_console_if;

    logic        stb_o;
    logic        we_o;
    logic [11:0] adr_o;
    logic [15:0] dat_o;
    logic        byte_o;
    logic [15:0] dat_i;
    logic        ack_i;

    modport master (
        output stb_o, we_o, adr_o, dat_o, byte_o,
        input  dat_i, ack_i
    );

    modport slave (
        input  stb_o, we_o, adr_o, dat_o, byte_o,
        output dat_i, ack_i
    );

endinterface

// File: rtl/vdu_wb_master.sv
// Single-transfer handshake engine: accept on stb&&ack, wait ack low, then ack high.
// Writes release stb as soon as ack drops; reads hold stb until data returns.
module vdu_wb_master
    import vdu_console_pkg::*;
#(
    parameter int unsigned IdxW = 11
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_i,
    input  logic            we_i,
    input  logic [IdxW-1:0] adr_i,
    input  logic [15:0]     wdat_i,
    output logic            done_o,
    output logic [15:0]     rdat_o,
    output logic            stb_o,
    output logic            we_o,
    output logic [11:0]     adr_o,
    output logic [15:0]     dat_o,
    input  logic            ack_i,
    input  logic [15:0]     dat_i
);

    bus_state_e st_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q   <= BusIdle;
            stb_o  <= 1'b0;
            we_o   <= 1'b0;
            adr_o  <= '0;
            dat_o  <= '0;
            rdat_o <= '0;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (st_q)
                BusIdle: begin
                    if (req_i) begin
                        stb_o <= 1'b1;
                        we_o  <= we_i;
                        adr_o <= {11'(adr_i), 1'b0};
                        dat_o <= wdat_i;
                        st_q  <= BusAddr;
                    end
                end
                BusAddr: begin
                    if (ack_i) begin
                        st_q <= BusLow;
                    end
                end
                BusLow: begin
                    if (!ack_i) begin
                        if (we_o) begin
                            stb_o <= 1'b0;
                        end
                        st_q <= BusHigh;
                    end
                end
                BusHigh: begin
                    if (ack_i) begin
                        if (!we_o) begin
                            rdat_o <= dat_i;
                        end
                        stb_o  <= 1'b0;
                        done_o <= 1'b1;
                        st_q   <= BusIdle;
                    end
                end
                default: st_q <= BusIdle;
            endcase
        end
    end

endmodule

// File: rtl/vdu_console.sv
// Hardware teletype: turns a character stream into word writes on the VDU port,
// tracking the cursor, handling CR/LF/BS/FF and scrolling by copying rows up.
module vdu_console
    import vdu_console_pkg::*;
#(
    parameter int unsigned COLS      = 80,
    parameter int unsigned ROWS      = 25,
    parameter logic [7:0]  BLANK     = 8'h20,
    parameter logic [7:0]  INIT_ATTR = 8'h07
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       char_valid_i,
    input  logic [7:0] char_data_i,
    input  logic [7:0] char_attr_i,
    output logic       char_ready_o,
    vdu_console_if.master wb,
    output logic [6:0] cur_col_o,
    output logic [4:0] cur_row_o,
    output logic       busy_o
);

    localparam int unsigned Words = COLS * ROWS;
    localparam int unsigned IdxW  = idx_width(Words);

    localparam logic [IdxW-1:0] LastIdx    = IdxW'(Words - 1);
    localparam logic [IdxW-1:0] ColsIdx    = IdxW'(COLS);
    localparam logic [IdxW-1:0] LastRowIdx = IdxW'(Words - COLS);
    localparam logic [6:0]      LastCol    = 7'(COLS - 1);
    localparam logic [4:0]      LastRow    = 5'(ROWS - 1);

    state_e          state_q;
    logic [IdxW-1:0] idx_q;
    logic [IdxW-1:0] base_q;
    logic [6:0]      col_q;
    logic [4:0]      row_q;
    logic [7:0]      char_q;
    logic [7:0]      attr_q;
    logic [7:0]      fill_q;
    logic            req_q;
    logic            issued_q;

    logic            done;
    logic [15:0]     rdat;
    logic            step;
    logic            bus_we;
    logic [IdxW-1:0] bus_adr;
    logic [15:0]     bus_wdat;

    assign char_ready_o = (state_q == StIdle);
    assign busy_o       = (state_q != StIdle);
    assign cur_col_o    = col_q;
    assign cur_row_o    = row_q;
    assign wb.byte_o    = 1'b0;
    assign step         = issued_q && done;

    always_comb begin
        bus_we   = 1'b1;
        bus_adr  = idx_q;
        bus_wdat = {fill_q, BLANK};
        unique case (state_q)
            StPut: begin
                bus_adr  = base_q + IdxW'(col_q);
                bus_wdat = {attr_q, char_q};
            end
            StScrRd:   bus_we = 1'b0;
            StScrWr: begin
                bus_adr  = idx_q - ColsIdx;
                bus_wdat = rdat;
            end
            StScrFill: bus_wdat = {attr_q, BLANK};
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StClear;
            idx_q    <= '0;
            base_q   <= '0;
            col_q    <= '0;
            row_q    <= '0;
            char_q   <= '0;
            attr_q   <= '0;
            fill_q   <= INIT_ATTR;
            req_q    <= 1'b0;
            issued_q <= 1'b0;
        end else begin
            req_q <= 1'b0;
            // One request per bus state visit; cleared again when the transfer retires.
            if (state_q != StIdle && !issued_q) begin
                req_q    <= 1'b1;
                issued_q <= 1'b1;
            end
            if (step) begin
                issued_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (char_valid_i) begin
                        char_q <= char_data_i;
                        attr_q <= char_attr_i;
                        if (char_data_i == CR) begin
                            col_q <= '0;
                        end else if (char_data_i == LF) begin
                            if (row_q != LastRow) begin
                                row_q  <= row_q + 5'd1;
                                base_q <= base_q + ColsIdx;
                            end else begin
                                idx_q   <= ColsIdx;
                                state_q <= StScrRd;
                            end
                        end else if (char_data_i == BS) begin
                            if (col_q != '0) begin
                                col_q <= col_q - 7'd1;
                            end
                        end else if (char_data_i == FF) begin
                            fill_q  <= char_attr_i;
                            col_q   <= '0;
                            row_q   <= '0;
                            base_q  <= '0;
                            idx_q   <= '0;
                            state_q <= StClear;
                        end else if (char_data_i >= 8'h20) begin
                            state_q <= StPut;
                        end
                    end
                end
                StClear, StScrFill: begin
                    if (step) begin
                        if (idx_q == LastIdx) begin
                            idx_q   <= '0;
                            state_q <= StIdle;
                        end else begin
                            idx_q <= idx_q + IdxW'(1);
                        end
                    end
                end
                StPut: begin
                    if (step) begin
                        if (col_q == LastCol) begin
                            col_q <= '0;
                            if (row_q != LastRow) begin
                                row_q   <= row_q + 5'd1;
                                base_q  <= base_q + ColsIdx;
                                state_q <= StIdle;
                            end else begin
                                idx_q   <= ColsIdx;
                                state_q <= StScrRd;
                            end
                        end else begin
                            col_q   <= col_q + 7'd1;
                            state_q <= StIdle;
                        end
                    end
                end
                StScrRd: begin
                    if (step) begin
                        state_q <= StScrWr;
                    end
                end
                StScrWr: begin
                    if (step) begin
                        if (idx_q == LastIdx) begin
                            idx_q   <= LastRowIdx;
                            state_q <= StScrFill;
                        end else begin
                            idx_q   <= idx_q + IdxW'(1);
                            state_q <= StScrRd;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    vdu_wb_master #(
        .IdxW (IdxW)
    ) u_wb_master (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (req_q),
        .we_i   (bus_we),
        .adr_i  (bus_adr),
        .wdat_i (bus_wdat),
        .done_o (done),
        .rdat_o (rdat),
        .stb_o  (wb.stb_o),
        .we_o   (wb.we_o),
        .adr_o  (wb.adr_o),
        .dat_o  (wb.dat_o),
        .ack_i  (wb.ack_i),
        .dat_i  (wb.dat_i)
    );

endmodule

// File: tb/tb_vdu_console.sv
// Scoreboard bench for vdu_console: a screen-level model predicts every bus transfer,
// a responder plays the VDU, and a monitor checks each transfer as it is accepted.
module tb_vdu_console;

    localparam int COLS  = 80;
    localparam int ROWS  = 25;
    localparam int WORDS = COLS * ROWS;

    typedef struct {
        bit          we;
        int          idx;
        logic [15:0] dat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b1;
    logic       char_valid = 1'b0;
    logic [7:0] char_data = '0;
    logic [7:0] char_attr = '0;
    logic       char_ready;
    logic       busy;
    logic [6:0] cur_col;
    logic [4:0] cur_row;

    vdu_console_if wb ();

    vdu_console #(
        .COLS      (COLS),
        .ROWS      (ROWS),
        .BLANK     (8'h20),
        .INIT_ATTR (8'h07)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .char_valid_i (char_valid),
        .char_data_i  (char_data),
        .char_attr_i  (char_attr),
        .char_ready_o (char_ready),
        .wb           (wb.master),
        .cur_col_o    (cur_col),
        .cur_row_o    (cur_row),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          xfers = 0;
    exp_t        exp_q[$];
    logic [15:0] vdu_mem[WORDS];
    logic [15:0] model_mem[WORDS];
    int          m_col;
    int          m_row;
    logic [7:0]  m_fill;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Screen model: what a teletype should do to a COLS x ROWS grid.
    function automatic void push_w(input int idx, input logic [15:0] d);
        exp_t e;
        e.we = 1'b1; e.idx = idx; e.dat = d;
        exp_q.push_back(e);
        model_mem[idx] = d;
    endfunction

    function automatic void push_r(input int idx);
        exp_t e;
        e.we = 1'b0; e.idx = idx; e.dat = '0;
        exp_q.push_back(e);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < WORDS; i++) push_w(i, {m_fill, 8'h20});
        m_col = 0;
        m_row = 0;
    endfunction

    function automatic void model_scroll(input logic [7:0] a);
        for (int i = COLS; i < WORDS; i++) begin
            push_r(i);
            push_w(i - COLS, model_mem[i]);
        end
        for (int i = WORDS - COLS; i < WORDS; i++) push_w(i, {a, 8'h20});
    endfunction

    function automatic void model_char(input logic [7:0] c, input logic [7:0] a);
        if (c == 8'h0D) m_col = 0;
        else if (c == 8'h0A) begin
            if (m_row < ROWS - 1) m_row++;
            else model_scroll(a);
        end else if (c == 8'h08) begin
            if (m_col > 0) m_col--;
        end else if (c == 8'h0C) begin
            m_fill = a;
            model_clear();
        end else if (c >= 8'h20) begin
            push_w(m_row * COLS + m_col, {a, c});
            m_col++;
            if (m_col == COLS) begin
                m_col = 0;
                if (m_row < ROWS - 1) m_row++;
                else model_scroll(a);
            end
        end
    endfunction

    // VDU responder: ack idles high, drops for 3 cycles per accepted transfer.
    initial begin
        int  idx;
        bit  we;
        wb.ack_i = 1'b1;
        wb.dat_i = '0;
        forever begin
            @(negedge clk);
            if (wb.stb_o && wb.ack_i && rst_ni) begin
                idx = int'(wb.adr_o >> 1);
                we  = wb.we_o;
                if (we) vdu_mem[idx] = wb.dat_o;
                @(posedge clk);
                #1 wb.ack_i = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                if (!we) wb.dat_i = vdu_mem[idx];
                wb.ack_i = 1'b1;
                @(posedge clk);
            end
        end
    end

    // Monitor: each accepted transfer is matched against the head of the scoreboard.
    initial begin
        bit   in_xfer;
        exp_t e;
        in_xfer = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_ni || !wb.stb_o) in_xfer = 1'b0;
            else if (wb.ack_i && !in_xfer) begin
                in_xfer = 1'b1;
                xfers++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_xfer actual we=%0b adr=%0h required none",
                             wb.we_o, wb.adr_o);
                end else begin
                    e = exp_q.pop_front();
                    check("bus_we", wb.we_o, e.we);
                    check("bus_adr", wb.adr_o, 32'(e.idx * 2));
                    if (e.we) check("bus_dat", wb.dat_o, e.dat);
                    check("byte_sel", wb.byte_o, 0);
                end
            end
        end
    end

    task automatic send_char(input logic [7:0] c, input logic [7:0] a);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        char_valid = 1'b1;
        char_data  = c;
        char_attr  = a;
        do begin
            @(negedge clk);
            n++;
        end while (!char_ready && n < 60000);
        if (!char_ready) begin
            $display("FAIL accept_timeout actual ready=0 required ready=1");
            $fatal(1, "accept timeout");
        end
        @(posedge clk);
        #1 char_valid = 1'b0;
        model_char(c, a);
    endtask

    task automatic wait_quiet(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || exp_q.size() != 0) && n < 60000);
        checks++;
        if (busy || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout actual pending=%0d busy=%0b required pending=0 busy=0",
                     name, exp_q.size(), busy);
        end
    endtask

    task automatic check_state(input string name);
        check({name, "_col"}, cur_col, m_col);
        check({name, "_row"}, cur_row, m_row);
        check({name, "_ready"}, char_ready, 1);
        check({name, "_busy"}, busy, 0);
    endtask

    task automatic check_mem(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < WORDS; i++) if (vdu_mem[i] !== model_mem[i]) bad++;
        check({name, "_mem_bad_words"}, bad, 0);
    endtask

    function automatic logic [7:0] rnd_print();
        return 8'($urandom_range(32, 255));
    endfunction

    initial begin
        #1200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0;
        logic [7:0] c;
        int r;

        #2 rst_ni = 1'b0;
        #1;
        check("rst_stb", wb.stb_o, 0);
        check("rst_we", wb.we_o, 0);
        check("rst_adr", wb.adr_o, 0);
        check("rst_dat", wb.dat_o, 0);
        check("rst_ready", char_ready, 0);
        check("rst_busy", busy, 1);
        check("rst_col", cur_col, 0);
        check("rst_row", cur_row, 0);
        m_fill = 8'h07;
        model_clear();
        x0 = xfers;
        repeat (2) @(posedge clk);
        #3 rst_ni = 1'b1;
        wait_quiet("clear0");
        check_state("clear0");
        check_mem("clear0");
        check("clear0_xfers", xfers - x0, 2000);
        check("clear0_last", vdu_mem[1999], 16'h0720);

        send_char(8'h41, 8'h1E);
        wait_quiet("char_a");
        check_state("char_a");
        check("char_a_word0", vdu_mem[0], 16'h1E41);

        for (int i = 0; i < 3; i++) send_char(8'h0A, 8'($urandom));
        send_char(8'h0D, 8'h00);
        for (int i = 0; i < 79; i++) send_char(rnd_print(), 8'($urandom));
        wait_quiet("to_79_3");
        check_state("at_79_3");
        check("at_79_3_col_const", cur_col, 79);
        send_char(8'h5A, 8'h4F);
        wait_quiet("wrap");
        check_state("wrap");
        check("wrap_word319", vdu_mem[319], 16'h4F5A);
        check("wrap_row_const", cur_row, 4);

        // Back-to-back random mix; sources hold characters while the console is busy.
        for (int i = 0; i < 150; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6) c = rnd_print();
            else if (r == 6) c = 8'h0D;
            else if (r == 7) c = 8'h08;
            else if (r == 8) c = (m_row < 20) ? 8'h0A : 8'h0D;
            else begin
                c = 8'($urandom_range(0, 31));
                if (c == 8'h0C || c == 8'h0A) c = 8'h01;
            end
            send_char(c, 8'($urandom));
        end
        wait_quiet("random");
        check_state("random");
        check_mem("random");

        while (m_row < ROWS - 1) send_char(8'h0A, 8'($urandom));
        send_char(8'h0D, 8'h00);
        wait_quiet("to_row24");
        check_state("at_row24");
        x0 = xfers;
        send_char(8'h0A, 8'h07);
        wait_quiet("scroll");
        check_state("scroll");
        check("scroll_row_const", cur_row, 24);
        check("scroll_xfers", xfers - x0, 1920 * 2 + 80);
        check_mem("scroll");
        check("scroll_fill", vdu_mem[1999], 16'h0720);

        x0 = xfers;
        send_char(8'h08, 8'h07);
        wait_quiet("bs0");
        check_state("bs0");
        for (int i = 0; i < 5; i++) send_char(rnd_print(), 8'h07);
        wait_quiet("five");
        check("five_col", cur_col, 5);
        send_char(8'h0D, 8'h07);
        wait_quiet("cr5");
        check_state("cr5");
        send_char(rnd_print(), 8'h07);
        send_char(rnd_print(), 8'h07);
        wait_quiet("two");
        send_char(8'h07, 8'h07);
        wait_quiet("bel");
        check_state("bel");
        check("bel_col", cur_col, 2);
        check("ctrl_xfers", xfers - x0, 7);

        // Interrupt a scroll while a row-copy write is in its ack-low phase.
        send_char(8'h0A, 8'h5A);
        r = 0;
        do begin
            @(negedge clk);
            r++;
        end while (!(wb.stb_o && wb.we_o && !wb.ack_i) && r < 2000);
        check("scrwr_seen", wb.stb_o && wb.we_o && !wb.ack_i, 1);
        #1 rst_ni = 1'b0;
        #1;
        check("async_stb", wb.stb_o, 0);
        check("async_busy", busy, 1);
        check("async_col", cur_col, 0);
        check("async_row", cur_row, 0);
        exp_q.delete();
        m_fill = 8'h07;
        model_clear();
        x0 = xfers;
        @(negedge clk);
        rst_ni = 1'b1;
        wait_quiet("clear1");
        check_state("clear1");
        check_mem("clear1");
        check("clear1_xfers", xfers - x0, 2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
